// File: rtl/register_file_pkg.sv
// Shared defaults and helpers for the parameterised register file.
package register_file_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_REGS = 4;
  localparam int unsigned ZERO_ADDR    = 0;

  // True when addr is the hard-wired zero register and that feature is enabled.
  function automatic logic isZeroAddr(input int unsigned addr, input logic zeroReg);
    return zeroReg && (addr == ZERO_ADDR);
  endfunction

endpackage

// File: rtl/register_file_param_scoreboard.sv
// Per-register busy bits with set-over-clear priority and a registered population count.
module reg_scoreboard
  import register_file_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   RD,
  input  logic                ResValid,
  input  logic [ADDR_W-1:0]   ResAddr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     BusyCount
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [NUM_REGS-1:0] busyNext;
  logic [CNT_W-1:0]    countNext;

  // Next busy vector: a write retires, a new reservation wins over a same-cycle retire.
  always_comb begin
    busyNext  = busy;
    countNext = '0;
    if (RegWrite) busyNext[RD] = 1'b0;
    if (ResValid) busyNext[ResAddr] = 1'b1;
    if (ZERO_REG != 0) busyNext[ZERO_ADDR] = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      countNext = countNext + CNT_W'(busyNext[i]);
    end
  end

  // Busy bits and their count move together so the count never lags the bits.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy      <= '0;
      BusyCount <= '0;
    end else begin
      busy      <= busyNext;
      BusyCount <= countNext;
    end
  end

endmodule

// File: rtl/register_file_param.sv
// Parameterised register file with optional zero register, write bypass and busy scoreboard.
module register_file_param
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              ResValid,
  input  logic [ADDR_W-1:0] ResAddr,
  output logic [DATA_W-1:0] ReadRS,
  output logic [DATA_W-1:0] ReadRT,
  output logic              BusyRS,
  output logic              BusyRT,
  output logic [ADDR_W:0]   BusyCount
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busyVec;
  logic                zeroEn;
  logic                wrEn;
  logic                zeroRS;
  logic                zeroRT;
  logic                bypassRS;
  logic                bypassRT;

  // Decode of zero-register hits and live bypass paths; bypass is muted while in reset.
  always_comb begin
    zeroEn   = (ZERO_REG != 0);
    wrEn     = RegWrite && !isZeroAddr(32'(RD), zeroEn);
    zeroRS   = isZeroAddr(32'(RS), zeroEn);
    zeroRT   = isZeroAddr(32'(RT), zeroEn);
    bypassRS = (BYPASS != 0) && RegWrite && !Reset && (RS == RD);
    bypassRT = (BYPASS != 0) && RegWrite && !Reset && (RT == RD);
  end

  // Storage array; writes to the zero register are dropped.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[RD] <= WriteData;
    end
  end

  // Read muxes: array value, overridden by bypass, overridden by the zero register.
  always_comb begin
    ReadRS = regs[RS];
    ReadRT = regs[RT];
    if (bypassRS) ReadRS = WriteData;
    if (bypassRT) ReadRT = WriteData;
    if (zeroRS) ReadRS = '0;
    if (zeroRT) ReadRT = '0;
  end

  // Busy flags: a bypassed write hides the busy bit unless a reservation re-targets it.
  always_comb begin
    BusyRS = busyVec[RS];
    BusyRT = busyVec[RT];
    if (bypassRS && !(ResValid && (ResAddr == RS))) BusyRS = 1'b0;
    if (bypassRT && !(ResValid && (ResAddr == RT))) BusyRT = 1'b0;
    if (zeroRS) BusyRS = 1'b0;
    if (zeroRT) BusyRT = 1'b0;
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) uScoreboard (
    .Clock     (Clock),
    .Reset     (Reset),
    .RegWrite  (RegWrite),
    .RD        (RD),
    .ResValid  (ResValid),
    .ResAddr   (ResAddr),
    .busy      (busyVec),
    .BusyCount (BusyCount)
  );

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: two 4x16 instances (zero+bypass, plain) share stimulus; a 16x32 instance is checked separately.
module tb_register_file_param;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  RS = '0, RT = '0, RD = '0, ResAddr = '0;
  logic [15:0] WriteData = '0;
  logic        RegWrite = 1'b0, ResValid = 1'b0;

  logic [15:0] readRsA, readRtA, readRsB, readRtB;
  logic        busyRsA, busyRtA, busyRsB, busyRtB;
  logic [2:0]  cntA, cntB;

  logic [3:0]  cRS = '0, cRT = '0, cRD = '0, cResAddr = '0;
  logic [31:0] cWriteData = '0;
  logic        cRegWrite = 1'b0, cResValid = 1'b0;
  logic [31:0] cReadRS, cReadRT;
  logic        cBusyRS, cBusyRT;
  logic [4:0]  cCount;

  always #5 Clock = ~Clock;

  register_file_param #(.DATA_W(16), .NUM_REGS(4), .ZERO_REG(1), .BYPASS(1)) dutA (
    .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD), .WriteData(WriteData),
    .RegWrite(RegWrite), .ResValid(ResValid), .ResAddr(ResAddr),
    .ReadRS(readRsA), .ReadRT(readRtA), .BusyRS(busyRsA), .BusyRT(busyRtA), .BusyCount(cntA));

  register_file_param #(.DATA_W(16), .NUM_REGS(4), .ZERO_REG(0), .BYPASS(0)) dutB (
    .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD), .WriteData(WriteData),
    .RegWrite(RegWrite), .ResValid(ResValid), .ResAddr(ResAddr),
    .ReadRS(readRsB), .ReadRT(readRtB), .BusyRS(busyRsB), .BusyRT(busyRtB), .BusyCount(cntB));

  register_file_param #(.DATA_W(32), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(1)) dutC (
    .Clock(Clock), .Reset(Reset), .RS(cRS), .RT(cRT), .RD(cRD), .WriteData(cWriteData),
    .RegWrite(cRegWrite), .ResValid(cResValid), .ResAddr(cResAddr),
    .ReadRS(cReadRS), .ReadRT(cReadRT), .BusyRS(cBusyRS), .BusyRT(cBusyRT), .BusyCount(cCount));

  typedef struct {
    logic [15:0] rs [2];
    logic [15:0] rt [2];
    logic        brs [2];
    logic        brt [2];
    logic [2:0]  cnt [2];
  } exp_t;

  exp_t        expQ [$];
  int          nCompared = 0;
  int          nMismatched = 0;

  // Reference state: index 0 = zero-reg + bypass config, index 1 = plain config.
  logic [15:0] mr [2][4];
  bit          mb [2][4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] expRead(int c, logic [1:0] a);
    if (c == 0 && a == 2'd0) return 16'h0;
    if (c == 0 && !Reset && RegWrite && a == RD) return WriteData;
    return mr[c][a];
  endfunction

  function automatic logic expBusy(int c, logic [1:0] a);
    if (c == 0 && a == 2'd0) return 1'b0;
    if (c == 0 && !Reset && RegWrite && a == RD && !(ResValid && ResAddr == a)) return 1'b0;
    return mb[c][a];
  endfunction

  function automatic logic [2:0] expCount(int c);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(mb[c][i]);
    return 3'(n);
  endfunction

  // Apply the rules for one rising edge to the reference state.
  task automatic commitEdge();
    if (!Reset) begin
      for (int c = 0; c < 2; c++) begin
        if (RegWrite && !(c == 0 && RD == 2'd0)) mr[c][RD] = WriteData;
        if (RegWrite) mb[c][RD] = 1'b0;
        if (ResValid && !(c == 0 && ResAddr == 2'd0)) mb[c][ResAddr] = 1'b1;
      end
    end
  endtask

  task automatic clearModel();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) begin
        mr[c][i] = 16'h0;
        mb[c][i] = 1'b0;
      end
  endtask

  // One cycle: advance the model at the edge, drive new inputs, queue the expected outputs.
  task automatic drive(input logic rst, input logic we, input logic [1:0] rd, input logic [15:0] wd,
                       input logic rv, input logic [1:0] ra, input logic [1:0] rs, input logic [1:0] rt);
    exp_t e;
    @(posedge Clock);
    commitEdge();
    #1;
    Reset = rst; RegWrite = we; RD = rd; WriteData = wd;
    ResValid = rv; ResAddr = ra; RS = rs; RT = rt;
    if (rst) clearModel();
    for (int c = 0; c < 2; c++) begin
      e.rs[c]  = expRead(c, rs);
      e.rt[c]  = expRead(c, rt);
      e.brs[c] = expBusy(c, rs);
      e.brt[c] = expBusy(c, rt);
      e.cnt[c] = expCount(c);
    end
    expQ.push_back(e);
  endtask

  // Monitor: outputs are settled mid-cycle; compare against the oldest expectation.
  always @(negedge Clock) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      chk("A.ReadRS", 32'(readRsA), 32'(e.rs[0]));
      chk("A.ReadRT", 32'(readRtA), 32'(e.rt[0]));
      chk("A.BusyRS", 32'(busyRsA), 32'(e.brs[0]));
      chk("A.BusyRT", 32'(busyRtA), 32'(e.brt[0]));
      chk("A.BusyCount", 32'(cntA), 32'(e.cnt[0]));
      chk("B.ReadRS", 32'(readRsB), 32'(e.rs[1]));
      chk("B.ReadRT", 32'(readRtB), 32'(e.rt[1]));
      chk("B.BusyRS", 32'(busyRsB), 32'(e.brs[1]));
      chk("B.BusyRT", 32'(busyRtB), 32'(e.brt[1]));
      chk("B.BusyCount", 32'(cntB), 32'(e.cnt[1]));
    end
  end

  task automatic stepC(input logic we, input logic [3:0] rd, input logic [31:0] wd,
                       input logic rv, input logic [3:0] ra, input logic [3:0] rs, input logic [3:0] rt);
    @(posedge Clock);
    #1;
    cRegWrite = we; cRD = rd; cWriteData = wd; cResValid = rv; cResAddr = ra; cRS = rs; cRT = rt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, nCompared=%0d", nCompared);
    $fatal(1, "watchdog");
  end

  initial begin
    clearModel();
    // Reset state, then release between edges.
    drive(1, 0, 0, 16'h0, 0, 0, 1, 2);
    @(negedge Clock); #1 Reset = 1'b0;

    // Basic write/read.
    drive(0, 1, 1, 16'd5, 0, 0, 0, 0);
    drive(0, 1, 2, 16'd7, 0, 0, 0, 0);
    drive(0, 0, 0, 16'h0, 0, 0, 1, 2);
    @(negedge Clock);
    chk("d031.ReadRS", 32'(readRsA), 32'd5);
    chk("d031.ReadRT", 32'(readRtA), 32'd7);

    // Same-cycle bypass versus old value.
    drive(0, 1, 3, 16'h1234, 0, 0, 0, 0);
    drive(0, 1, 3, 16'h00AA, 0, 0, 3, 3);
    @(negedge Clock);
    chk("d032.bypassA", 32'(readRsA), 32'h00AA);
    chk("d032.oldB", 32'(readRsB), 32'h1234);
    drive(0, 0, 0, 16'h0, 0, 0, 3, 3);

    // Zero register ignores writes and reservations.
    drive(0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
    drive(0, 0, 0, 16'h0, 0, 0, 0, 0);
    @(negedge Clock);
    chk("d033.zeroRead", 32'(readRsA), 32'h0);
    chk("d033.zeroCount", 32'(cntA), 32'h0);

    // Reservations, retirement, and same-cycle reserve+write.
    drive(0, 0, 0, 16'h0, 1, 1, 0, 0);
    drive(0, 0, 0, 16'h0, 1, 2, 1, 2);
    drive(0, 0, 0, 16'h0, 0, 0, 1, 2);
    @(negedge Clock);
    chk("d034.count2", 32'(cntA), 32'd2);
    drive(0, 1, 1, 16'h0011, 0, 0, 1, 2);
    drive(0, 1, 2, 16'h0022, 1, 2, 1, 2);
    drive(0, 0, 0, 16'h0, 0, 0, 2, 1);
    @(negedge Clock);
    chk("d034.busy2", 32'(busyRsA), 32'd1);
    chk("d034.data2", 32'(readRsA), 32'h0022);
    chk("d034.count1", 32'(cntA), 32'd1);

    // Load and reserve 1..3, then reset between edges.
    for (int i = 1; i < 4; i++) drive(0, 1, 2'(i), 16'd9, 1, 2'(i), 0, 0);
    drive(0, 0, 0, 16'h0, 0, 0, 1, 3);
    drive(1, 0, 0, 16'h0, 0, 0, 1, 3);
    @(negedge Clock);
    chk("d035.read", 32'(readRsA), 32'h0);
    chk("d035.count", 32'(cntA), 32'h0);
    #1 Reset = 1'b0;

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), 16'($urandom),
            1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    end
    drive(0, 0, 0, 16'h0, 0, 0, 0, 0);
    repeat (3) @(negedge Clock);
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    // Wide instance: every register holds a distinct pattern, read through both ports.
    for (int i = 0; i < 16; i++) stepC(1, 4'(i), 32'(i) * 32'h01010101, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      stepC(0, 0, 32'h0, 0, 0, 4'(i), 4'(15 - i));
      @(negedge Clock);
      chk($sformatf("c.RS%0d", i), cReadRS, 32'(i) * 32'h01010101);
      chk($sformatf("c.RT%0d", 15 - i), cReadRT, 32'(15 - i) * 32'h01010101);
    end
    for (int i = 0; i < 16; i++) stepC(0, 0, 32'h0, 1, 4'(i), 0, 0);
    stepC(0, 0, 32'h0, 0, 0, 0, 5);
    @(negedge Clock);
    chk("c.countMax", 32'(cCount), 32'd15);
    chk("c.busyZero", 32'(cBusyRS), 32'd0);
    chk("c.busy5", 32'(cBusyRT), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 The block SHALL have parameter DATA_W, 16, width of each register and data port.
REQ-002 The block SHALL have parameter NUM_REGS, 4, register count; power of two, minimum 2.
REQ-003 The block SHALL have parameter ADDR_W, $clog2(NUM_REGS), address width of RS/RT/RD/ResAddr.
REQ-004 The block SHALL have parameter ZERO_REG, 1, where 1 makes register 0 read as zero and ignore writes and reservations.
REQ-005 The block SHALL have parameter BYPASS, 1, where 1 forwards same-cycle WriteData to matching read ports.
REQ-006 The block SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-008 The block SHALL have ports RS, RT  input  ADDR_W  read addresses.
REQ-009 The block SHALL have port RD  input  ADDR_W  write address.
REQ-010 The block SHALL have port WriteData  input  DATA_W  write data.
REQ-011 The block SHALL have port RegWrite  input  1  write enable.
REQ-012 The block SHALL have ports ResValid, ResAddr  input  1 / ADDR_W  scoreboard reservation request and target.
REQ-013 The block SHALL have ports ReadRS, ReadRT  output  DATA_W  combinational read data.
REQ-014 The block SHALL have ports BusyRS, BusyRT  output  1  pending-write flag for RS / RT.
REQ-015 The block SHALL have port BusyCount  output  ADDR_W+1  number of registers currently reserved.

Function
REQ-016 On a rising Clock edge with RegWrite=1, regs[RD] SHALL take WriteData; with ZERO_REG=1 and RD=0 the write SHALL be dropped.
REQ-017 ReadRS/ReadRT SHALL equal regs[RS]/regs[RT] combinationally, with no added latency.
REQ-018 With BYPASS=1, RegWrite=1 and RS==RD (or RT==RD), the matching read SHALL return WriteData in the same cycle; with BYPASS=0 it SHALL return the old value until after the edge.
REQ-019 With ZERO_REG=1, reads of address 0 SHALL return 0 regardless of bypass.
REQ-020 Each register SHALL carry a busy bit: ResValid=1 sets busy[ResAddr] at the edge; RegWrite=1 clears busy[RD] at the edge.
REQ-021 When ResValid=1, RegWrite=1 and ResAddr==RD in the same cycle, the write SHALL complete and busy SHALL end set (new reservation wins).
REQ-022 A reservation of an already-busy register SHALL leave it busy; a write to a non-busy register SHALL leave it not busy.
REQ-023 With ZERO_REG=1, reservations of address 0 SHALL be ignored and BusyRS/BusyRT for address 0 SHALL be 0.
REQ-024 BusyRS SHALL be busy[RS], forced to 0 when BYPASS=1 and a same-cycle write to RS is present and ResValid does not target RS; BusyRT likewise.
REQ-025 BusyCount SHALL equal the population count of busy bits, updated at the same edge as the bits, and SHALL never exceed NUM_REGS (or NUM_REGS-1 with ZERO_REG=1).

Reset
REQ-026 Reset=1 SHALL immediately, without waiting for Clock, clear every register to 0, every busy bit to 0 and BusyCount to 0.
REQ-027 While Reset=1, writes and reservations SHALL be ignored; a write coinciding with Reset deassertion SHALL take effect only at the first rising edge after deassertion.
REQ-028 Reset asserted mid-sequence SHALL discard all pending reservations; no busy state SHALL survive.

Structure
REQ-029 Default widths, NUM_REGS default and the zero-register address constant SHALL live in shared package register_file_pkg.
REQ-030 The busy bits, set/clear priority and BusyCount SHALL be a sub-module named reg_scoreboard; the storage array and read/bypass muxing SHALL stay in register_file_param.

Verification
REQ-031 Write RD=1 with 5 and RD=2 with 7 on two edges, then RS=1, RT=2 -> ReadRS=5, ReadRT=7.
REQ-032 RegWrite=1, RD=3, WriteData=0x00AA, RS=3 before the edge -> BYPASS=1: ReadRS=0x00AA same cycle; BYPASS=0: old value, 0x00AA after the edge.
REQ-033 ZERO_REG=1: write 0xFFFF to RD=0 and reserve address 0 -> ReadRS(RS=0)=0, BusyRS=0, BusyCount unchanged.
REQ-034 Reserve 1 then 2 -> BusyCount=2; write RD=1 -> BusyRS(RS=1)=0, BusyCount=1; same-cycle reserve+write to 2 -> busy[2] stays 1, data updated.
REQ-035 Load regs 1..3 with 9 and reserve 1..3, pulse Reset between clock edges -> all reads 0, all Busy 0, BusyCount=0 before next edge.
REQ-036 NUM_REGS=16, DATA_W=32: write each register with its index times 0x01010101, read all via both ports -> values match, no aliasing.
